msrv32_fetch_sequencer: RTL
===========================

Name: msrv32_fetch_sequencer

Overview:
Sequences the program-counter mux and the instruction-fetch handshake for the MSRV32 core. It drives the 2-bit PC source select: 00 boot, 01 trap return, 10 trap taken, 11 operate. It also drives the PC register load enable, pipeline flush and EPC capture. Trap, misaligned-fetch and MRET redirects are arbitrated with request/ack handshakes and held across AHB wait states.

Parameters:
TIMEOUT_CYCLES, 255, consecutive ahb_ready_in-low cycles in OPERATING before a fetch bus fault (used only with the optional feature).
CNT_W, 8, width of the stall counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
ms_riscv32_mp_clk_in  input  1  core clock; all state updates on its rising edge
ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset
ahb_ready_in  input  1  instruction-bus HREADY; a fetch/redirect completes only in a cycle where it is high
branch_taken_in  input  1  the current instruction redirects the PC
misaligned_instr_in  input  1  the next PC is misaligned (from the PC block)
trap_req_in  input  1  trap request from machine control; held high until trap_ack_out
trap_cause_in  input  4  cause code accompanying trap_req_in
mret_req_in  input  1  MRET request; held high until mret_ack_out
pc_src_out  output  2  PC mux select
pc_load_out  output  1  load enable for the PC / instruction-address register
flush_out  output  1  kill the instruction in decode
epc_we_out  output  1  write the current PC into EPC
trap_cause_out  output  4  cause code to be written with EPC
trap_ack_out  output  1  one-cycle pulse: trap redirect completed
mret_ack_out  output  1  one-cycle pulse: return redirect completed
bus_fault_out  output  1  one-cycle pulse: fetch timeout (0 when the feature is absent)

Behaviour:
- One clock domain: ms_riscv32_mp_clk_in. Reset ms_riscv32_mp_rst_in is synchronous and active-high.
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN. The state is registered; all outputs are combinational from the state and inputs.
- Reset while rst is high: state goes to RESET. Outputs: pc_src 00, flush 1, pc_load 0, all acks and epc_we 0, trap_cause_out 0, stall counter 0.
- RESET with rst low: pc_src 00 and pc_load = ahb_ready_in. Moves to OPERATING when ahb_ready_in is high.
- OPERATING: pc_src 11 and pc_load = ahb_ready_in. flush = branch_taken_in & ahb_ready_in.
- OPERATING exit priority, evaluated every cycle regardless of ready:
  - misaligned_instr_in & branch_taken_in: go to TRAP_TAKEN, latch cause 0.
  - otherwise trap_req_in: go to TRAP_TAKEN, latch trap_cause_in.
  - otherwise mret_req_in: go to TRAP_RETURN.
- On the cycle of any OPERATING exit: epc_we_out = 1 only for the TRAP_TAKEN exits. trap_cause_out then shows the latched value and holds it until the next trap.
- TRAP_TAKEN: pc_src 10, flush 1, pc_load = ahb_ready_in.
  - When ahb_ready_in is high: trap_ack_out pulses (only if the trap came from trap_req_in) and state goes to OPERATING.
  - Otherwise the state holds.
- TRAP_RETURN: pc_src 01, flush 1, pc_load = ahb_ready_in. When ahb_ready_in is high: mret_ack_out pulses and state goes to OPERATING.
- Requests arriving in TRAP_TAKEN or TRAP_RETURN are not acknowledged. They are serviced from OPERATING by the requester holding the request, so there is at most one ack per request.
- Simultaneous trap_req_in and mret_req_in: the trap wins. The MRET is taken in a later OPERATING cycle if still held.
- Reset mid-redirect: the redirect is abandoned, no ack is issued, and the state goes to RESET on the next edge.

Optional Feature:
MSRV32_FETCH_TIMEOUT_EN
- Defined: in OPERATING, a counter increments on each ahb_ready_in-low cycle and clears on ready-high or state exit.
- When the counter reaches TIMEOUT_CYCLES: bus_fault_out pulses, cause 1 (instruction access fault) is latched, epc_we_out = 1, and state goes to TRAP_TAKEN. This outranks all other requests in that cycle.
- Undefined: no counter is built and bus_fault_out is tied to 0.

Decomposition:
- Package msrv32_fetch_pkg holds:
  - state encoding localparams;
  - PC_SRC_BOOT/EPC/TRAP/NEXT = 00/01/10/11;
  - cause codes CAUSE_IADDR_MISALIGNED = 0, CAUSE_IACCESS_FAULT = 1.
- One natural sub-module: msrv32_fetch_timeout (stall counter plus compare), instantiated only under the macro.

Test Plan:
- Hold rst 3 cycles with ahb_ready=1, then release → pc_src 00 and flush 1 during reset; pc_load 1 on the first post-reset cycle; pc_src 11 on the next.
- In OPERATING, pulse branch_taken_in with misaligned_instr_in=1 → epc_we 1, trap_cause_out 0, pc_src 10 next cycle, no trap_ack.
- Assert trap_req_in with cause 4'hB and ahb_ready low for 3 cycles → pc_src 10 held 4 cycles; trap_ack pulses exactly once on the ready cycle; trap_cause_out = B.
- Assert trap_req_in and mret_req_in together and hold both → trap serviced first; mret_ack arrives after a return to OPERATING and TRAP_RETURN with pc_src 01.
- Assert rst during TRAP_RETURN with ready low → no mret_ack; state RESET and pc_src 00 next cycle.
- With MSRV32_FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, hold ready low in OPERATING → bus_fault pulse on the 4th low cycle, trap_cause_out 1, pc_src 10. Without the macro, bus_fault stays 0.

Source files
------------

// File: rtl/msrv32_fetch_pkg.sv
// Shared encodings for the MSRV32 fetch sequencer: FSM states, PC mux selects and fetch cause codes.
package msrv32_fetch_pkg;

    localparam logic [1:0] ST_RESET_ENC       = 2'b00;
    localparam logic [1:0] ST_OPERATING_ENC   = 2'b01;
    localparam logic [1:0] ST_TRAP_TAKEN_ENC  = 2'b10;
    localparam logic [1:0] ST_TRAP_RETURN_ENC = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET       = ST_RESET_ENC,
        ST_OPERATING   = ST_OPERATING_ENC,
        ST_TRAP_TAKEN  = ST_TRAP_TAKEN_ENC,
        ST_TRAP_RETURN = ST_TRAP_RETURN_ENC
    } fetch_state_e;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    localparam logic [3:0] CAUSE_IADDR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_IACCESS_FAULT    = 4'd1;

endpackage

// File: rtl/msrv32_fetch_timeout.sv
// Fetch stall watchdog: counts consecutive not-ready cycles while operating and flags the limit cycle.
module msrv32_fetch_timeout #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    input  logic exit_req,
    output logic fault
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             fault_s;

    // The limit is reached in the cycle whose own stall would bring the count to TIMEOUT_CYCLES.
    assign fault_s = active & ~ready & (cnt_r == LIMIT);
    assign fault   = fault_s;

    // Stall counter: cleared by reset, leaving OPERATING, a ready cycle or any redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!active || ready || exit_req || fault_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/msrv32_fetch_sequencer.sv
// MSRV32 PC-source / fetch redirect sequencer. Optional fetch timeout under MSRV32_FETCH_TIMEOUT_EN.
module msrv32_fetch_sequencer
    import msrv32_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_in,
    input  logic       ahb_ready_in,
    input  logic       branch_taken_in,
    input  logic       misaligned_instr_in,
    input  logic       trap_req_in,
    input  logic [3:0] trap_cause_in,
    input  logic       mret_req_in,
    output logic [1:0] pc_src_out,
    output logic       pc_load_out,
    output logic       flush_out,
    output logic       epc_we_out,
    output logic [3:0] trap_cause_out,
    output logic       trap_ack_out,
    output logic       mret_ack_out,
    output logic       bus_fault_out
);

    localparam bit CNT_W_OK = (2**CNT_W) > TIMEOUT_CYCLES;

    fetch_state_e state_r, state_nxt_s;
    logic [3:0]   cause_r, cause_nxt_s;
    logic         from_req_r, from_req_nxt_s;
    logic         fault_s;
    logic         op_exit_req_s;

    assign op_exit_req_s = (misaligned_instr_in & branch_taken_in) | trap_req_in | mret_req_in;

`ifdef MSRV32_FETCH_TIMEOUT_EN
    logic tmo_fault_s;

    msrv32_fetch_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk      (ms_riscv32_mp_clk_in),
        .rst      (ms_riscv32_mp_rst_in),
        .active   (state_r == ST_OPERATING),
        .ready    (ahb_ready_in),
        .exit_req (op_exit_req_s),
        .fault    (tmo_fault_s)
    );

    assign fault_s = tmo_fault_s & CNT_W_OK;
`else
    assign fault_s = 1'b0 & CNT_W_OK;
`endif

    // Next-state and output decode; outputs follow state and inputs in the same cycle.
    always_comb begin
        state_nxt_s    = state_r;
        cause_nxt_s    = cause_r;
        from_req_nxt_s = from_req_r;
        pc_src_out     = PC_SRC_BOOT;
        pc_load_out    = 1'b0;
        flush_out      = 1'b1;
        epc_we_out     = 1'b0;
        trap_cause_out = cause_r;
        trap_ack_out   = 1'b0;
        mret_ack_out   = 1'b0;
        bus_fault_out  = 1'b0;
        if (ms_riscv32_mp_rst_in) begin
            state_nxt_s    = ST_RESET;
            trap_cause_out = 4'h0;
        end else begin
            case (state_r)
                ST_RESET: begin
                    pc_load_out = ahb_ready_in;
                    if (ahb_ready_in) begin
                        state_nxt_s = ST_OPERATING;
                    end else begin
                        state_nxt_s = ST_RESET;
                    end
                end
                ST_OPERATING: begin
                    pc_src_out  = PC_SRC_NEXT;
                    pc_load_out = ahb_ready_in;
                    flush_out   = branch_taken_in & ahb_ready_in;
                    if (fault_s) begin
                        state_nxt_s    = ST_TRAP_TAKEN;
                        cause_nxt_s    = CAUSE_IACCESS_FAULT;
                        from_req_nxt_s = 1'b0;
                        epc_we_out     = 1'b1;
                        bus_fault_out  = 1'b1;
                        trap_cause_out = CAUSE_IACCESS_FAULT;
                    end else if (misaligned_instr_in && branch_taken_in) begin
                        state_nxt_s    = ST_TRAP_TAKEN;
                        cause_nxt_s    = CAUSE_IADDR_MISALIGNED;
                        from_req_nxt_s = 1'b0;
                        epc_we_out     = 1'b1;
                        trap_cause_out = CAUSE_IADDR_MISALIGNED;
                    end else if (trap_req_in) begin
                        state_nxt_s    = ST_TRAP_TAKEN;
                        cause_nxt_s    = trap_cause_in;
                        from_req_nxt_s = 1'b1;
                        epc_we_out     = 1'b1;
                        trap_cause_out = trap_cause_in;
                    end else if (mret_req_in) begin
                        state_nxt_s = ST_TRAP_RETURN;
                    end else begin
                        state_nxt_s = ST_OPERATING;
                    end
                end
                ST_TRAP_TAKEN: begin
                    pc_src_out  = PC_SRC_TRAP;
                    pc_load_out = ahb_ready_in;
                    if (ahb_ready_in) begin
                        trap_ack_out = from_req_r;
                        state_nxt_s  = ST_OPERATING;
                    end else begin
                        state_nxt_s = ST_TRAP_TAKEN;
                    end
                end
                ST_TRAP_RETURN: begin
                    pc_src_out  = PC_SRC_EPC;
                    pc_load_out = ahb_ready_in;
                    if (ahb_ready_in) begin
                        mret_ack_out = 1'b1;
                        state_nxt_s  = ST_OPERATING;
                    end else begin
                        state_nxt_s = ST_TRAP_RETURN;
                    end
                end
                default: begin
                    state_nxt_s = ST_RESET;
                end
            endcase
        end
    end

    // State, latched trap cause and trap origin registers.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_r    <= ST_RESET;
            cause_r    <= 4'h0;
            from_req_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cause_r    <= cause_nxt_s;
            from_req_r <= from_req_nxt_s;
        end
    end

endmodule
